acia_tx_sched: RTL and testbench
================================

Name: acia_tx_sched

Overview:
- Transmit-side scheduler for the ACIA. Arbitrates between two byte sources: a CPU write port (req/ack) and a posted echo port fed from the receive path.
- Accepted bytes are buffered in a small FIFO, then fed one at a time to the transmitter through its TXLATCH/TXDATA/TXFULL handshake.
- Sits between the register interface and the transmitter; all logic is in the PHI2 domain.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2.
- AW, 2, log2(DEPTH); pointer width.
- WDOG_CYCLES, 4096, stall limit in PHI2 cycles; used only with ACIA_TX_SCHED_WDOG_EN.

Ports:
- PHI2  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CPU_REQ  in  1  CPU has a byte; held with CPU_DATA stable until CPU_ACK.
- CPU_DATA  in  8  CPU byte.
- CPU_ACK  out  1  one-cycle pulse: CPU byte written into the FIFO this cycle.
- ECHO_WR  in  1  one-cycle strobe: echo byte valid.
- ECHO_DATA  in  8  echo byte.
- ECHO_EN  in  1  when 0, ECHO_WR is ignored.
- HOLD  in  1  when 1, no new byte is launched; the FIFO keeps accepting.
- TXFULL  in  1  transmitter holding register occupied.
- TXLATCH  out  1  one-cycle load strobe to the transmitter.
- TXDATA  out  8  byte presented with TXLATCH.
- FIFO_COUNT  out  AW+1  occupancy, 0..DEPTH.
- FIFO_EMPTY, FIFO_FULL  out  1 each  status flags.
- OVERRUN  out  1  sticky: an echo byte was dropped.
- STALL  out  1  sticky watchdog flag; constant 0 without the macro.
- ERR_CLR  in  1  clears OVERRUN and STALL.
- IDLE  out  1  FIFO empty, echo holding register empty, and FSM in S_IDLE.

Behaviour:
- Reset: all outputs 0 except FIFO_EMPTY=1 and IDLE=1. Pointers, count, echo holding register, RR priority bit (CPU first) and FSM (S_IDLE) are cleared. Reset mid-operation drops all buffered bytes. TXLATCH is never asserted during or in the cycle after reset.

Echo holding register (EH):
- ECHO_WR & ECHO_EN & EH empty → capture ECHO_DATA; EH becomes valid.
- ECHO_WR & ECHO_EN & EH valid & EH not granted this cycle → byte dropped, OVERRUN=1.
- EH granted in the same cycle as a new ECHO_WR → the new byte is captured, no overrun.

Arbiter (one FIFO write per cycle):
- Candidates: CPU_REQ and EH valid. A grant is issued only if FIFO is not full, or if a pop occurs this cycle.
- One candidate only → it wins.
- Both candidates → round-robin: the source not granted last wins; the priority bit toggles on every contested grant.
- CPU grant → CPU_ACK pulses in the write cycle; CPU must drop CPU_REQ or present the next byte by the following cycle.
- EH grant → EH becomes empty.

FIFO:
- Circular buffer; pointers wrap modulo DEPTH.
- Push and pop in the same cycle → count unchanged; allowed at full (pop frees the slot).

Drain FSM:
- S_IDLE: if !FIFO_EMPTY & !HOLD & !TXFULL → TXLATCH=1 and TXDATA=head for one cycle, pop, go to S_ACCEPT.
- S_ACCEPT: one cycle → S_DRAIN. This covers the transmitter's one-cycle TXFULL rise latency.
- S_DRAIN: wait until TXFULL=0 → S_IDLE.
- Minimum spacing between TXLATCH pulses is 3 cycles.
- TXDATA holds the last launched byte between launches.
- HOLD asserted in S_ACCEPT or S_DRAIN does not abort the current byte; it only blocks the next launch.

Error clear:
- ERR_CLR has priority over a same-cycle set. The event is lost, and this is documented behaviour.

Optional Feature:
- Macro: ACIA_TX_SCHED_WDOG_EN.
- With the macro: a counter runs while the FSM is in S_DRAIN. If it reaches WDOG_CYCLES with TXFULL still 1, STALL=1 (sticky) and the FSM returns to S_IDLE. The counter clears on entry to S_DRAIN.
- Without the macro: no counter; STALL is tied to 0 and S_DRAIN waits indefinitely.

Test Plan:
1. CPU_REQ with 0x41, TXFULL=0 → CPU_ACK next edge; TXLATCH one cycle later with TXDATA=0x41. Model TXFULL high for 10 cycles → next launch only after TXFULL falls.
2. Hold TXFULL=1 and write 0x01..0x05 via CPU → ACKs for 0x01..0x04; FIFO_FULL=1 and COUNT=4; 0x05 waits unacked. Release TXFULL → bytes launch in order 0x01..0x05.
3. CPU_REQ and EH valid together for four contested rounds → grants alternate CPU, ECHO, CPU, ECHO, starting with CPU after reset.
4. Hold TXFULL=1, fill FIFO, send ECHO_WR 0x55 then ECHO_WR 0x66 → 0x55 sits in EH, 0x66 dropped, OVERRUN=1. ERR_CLR → OVERRUN=0.
5. HOLD=1 with 3 bytes queued → no TXLATCH for 20 cycles. HOLD=0 → first launch next cycle. Assert RESET mid-drain → count=0 and no further TXLATCH.
6. (WDOG_EN, WDOG_CYCLES=16) launch a byte and keep TXFULL=1 → STALL=1 after 16 cycles in S_DRAIN and FSM back in S_IDLE. Without the macro, STALL stays 0.

Source files
------------

// File: rtl/acia_tx_sched_if.sv
// acia_tx_sched_if: register-side and transmitter-side signals of the ACIA
// transmit scheduler. The scheduler uses the slave modport; the driving
// environment (register interface, receive path, transmitter) uses master.
interface acia_tx_sched_if #(
  parameter int unsigned AW = 2
);
  logic          CPU_REQ;
  logic [7:0]    CPU_DATA;
  logic          CPU_ACK;
  logic          ECHO_WR;
  logic [7:0]    ECHO_DATA;
  logic          ECHO_EN;
  logic          HOLD;
  logic          TXFULL;
  logic          TXLATCH;
  logic [7:0]    TXDATA;
  logic [AW:0]   FIFO_COUNT;
  logic          FIFO_EMPTY;
  logic          FIFO_FULL;
  logic          OVERRUN;
  logic          STALL;
  logic          ERR_CLR;
  logic          IDLE;

  modport master (
    output CPU_REQ, CPU_DATA, ECHO_WR, ECHO_DATA, ECHO_EN, HOLD, TXFULL, ERR_CLR,
    input  CPU_ACK, TXLATCH, TXDATA, FIFO_COUNT, FIFO_EMPTY, FIFO_FULL,
           OVERRUN, STALL, IDLE
  );

  modport slave (
    input  CPU_REQ, CPU_DATA, ECHO_WR, ECHO_DATA, ECHO_EN, HOLD, TXFULL, ERR_CLR,
    output CPU_ACK, TXLATCH, TXDATA, FIFO_COUNT, FIFO_EMPTY, FIFO_FULL,
           OVERRUN, STALL, IDLE
  );
endinterface

// File: rtl/acia_tx_sched.sv
// acia_tx_sched: ACIA transmit scheduler. Round-robin arbitration between a
// CPU req/ack port and a one-byte echo holding register, a DEPTH-entry FIFO,
// and a three-state drain FSM driving the TXLATCH/TXDATA/TXFULL handshake.
// Optional drain watchdog: define ACIA_TX_SCHED_WDOG_EN.
module acia_tx_sched #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AW          = 2,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic           PHI2,
  input  logic           RESET,
  acia_tx_sched_if.slave bus
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH != (1 << AW) || WDOG_CYCLES < 2)
  begin : g_bad_cfg
    $error("acia_tx_sched: DEPTH must be a power of 2 >= 2 equal to 2**AW, WDOG_CYCLES >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_eh_valid;
  logic [7:0]    r_eh_data;
  logic          r_prio;      // 0: CPU wins the next contested grant
  logic [7:0]    r_txdata;
  logic          r_overrun;

  logic          w_empty, w_full, w_pop, w_push, w_can_push, w_contest;
  logic          w_cpu_gnt, w_eh_gnt, w_echo_in, w_drop;
  logic [7:0]    w_push_data;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_echo_in = bus.ECHO_WR && bus.ECHO_EN;
  assign w_drop    = w_echo_in && r_eh_valid && !w_eh_gnt;

`ifdef ACIA_TX_SCHED_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES);
  logic [WW-1:0] r_wdog;
  logic          r_stall, w_stall_set;
`endif

  // Arbiter: one FIFO write per cycle; a same-cycle pop frees a full slot.
  always_comb begin
    w_can_push = !RESET && (!w_full || w_pop);
    w_contest  = bus.CPU_REQ && r_eh_valid;
    w_cpu_gnt  = 1'b0;
    w_eh_gnt   = 1'b0;
    if (w_can_push) begin
      if (w_contest) begin
        w_cpu_gnt = !r_prio;
        w_eh_gnt  = r_prio;
      end else begin
        w_cpu_gnt = bus.CPU_REQ;
        w_eh_gnt  = r_eh_valid;
      end
    end
    w_push      = w_cpu_gnt || w_eh_gnt;
    w_push_data = w_cpu_gnt ? bus.CPU_DATA : r_eh_data;
  end

  // Drain FSM next-state; the launch (pop) happens in S_IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
`ifdef ACIA_TX_SCHED_WDOG_EN
    w_stall_set = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty && !bus.HOLD && !bus.TXFULL && !RESET) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!bus.TXFULL) begin
          w_state_nxt = S_IDLE;
        end
`ifdef ACIA_TX_SCHED_WDOG_EN
        else if (r_wdog == WW'(WDOG_CYCLES - 1)) begin
          w_stall_set = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge PHI2) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FIFO storage; stale entries are harmless because pointers reset.
  always_ff @(posedge PHI2) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  // FIFO pointers, occupancy and the last launched byte.
  always_ff @(posedge PHI2) begin
    if (RESET) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_txdata <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr   <= r_rptr + AW'(1);
        r_txdata <= r_mem[r_rptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Echo holding register, overrun flag and round-robin priority.
  always_ff @(posedge PHI2) begin
    if (RESET) begin
      r_eh_valid <= 1'b0;
      r_eh_data  <= '0;
      r_overrun  <= 1'b0;
      r_prio     <= 1'b0;
    end else begin
      if (w_echo_in && (!r_eh_valid || w_eh_gnt)) begin
        r_eh_valid <= 1'b1;
        r_eh_data  <= bus.ECHO_DATA;
      end else if (w_eh_gnt) begin
        r_eh_valid <= 1'b0;
      end
      if (bus.ERR_CLR)  r_overrun <= 1'b0;
      else if (w_drop)  r_overrun <= 1'b1;
      if (w_contest && w_push) r_prio <= !r_prio;
    end
  end

`ifdef ACIA_TX_SCHED_WDOG_EN
  // Drain watchdog: counts cycles spent in S_DRAIN, zero elsewhere.
  always_ff @(posedge PHI2) begin
    if (RESET || r_state != S_DRAIN) r_wdog <= '0;
    else                             r_wdog <= r_wdog + WW'(1);
  end

  // Sticky stall flag; clear wins over a same-cycle timeout.
  always_ff @(posedge PHI2) begin
    if (RESET || bus.ERR_CLR) r_stall <= 1'b0;
    else if (w_stall_set)     r_stall <= 1'b1;
  end

  assign bus.STALL = r_stall;
`else
  assign bus.STALL = 1'b0;
`endif

  assign bus.CPU_ACK    = w_cpu_gnt;
  assign bus.TXLATCH    = w_pop;
  assign bus.TXDATA     = w_pop ? r_mem[r_rptr] : r_txdata;
  assign bus.FIFO_COUNT = r_count;
  assign bus.FIFO_EMPTY = w_empty;
  assign bus.FIFO_FULL  = w_full;
  assign bus.OVERRUN    = r_overrun;
  assign bus.IDLE       = w_empty && !r_eh_valid && (r_state == S_IDLE);

endmodule

// File: tb/tb_acia_tx_sched.sv
// tb_acia_tx_sched: scoreboard bench for acia_tx_sched. Expected bytes are
// queued when stimulus is driven and checked by a TXLATCH monitor.
// Watchdog checks follow ACIA_TX_SCHED_WDOG_EN (built with WDOG_CYCLES=16).
module tb_acia_tx_sched;

  logic PHI2  = 1'b0;
  logic RESET = 1'b1;

  always #5 PHI2 = ~PHI2;

  acia_tx_sched_if #(.AW(2)) bus ();

  acia_tx_sched #(.DEPTH(4), .AW(2), .WDOG_CYCLES(16)) dut (
    .PHI2  (PHI2),
    .RESET (RESET),
    .bus   (bus)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb [$];
  int         launches    = 0;
  int         cyc         = 0;
  int         prev_launch = -100;
  logic       rst_d       = 1'b1;
  logic [7:0] mon_exp;

  always @(posedge PHI2) begin
    cyc   <= cyc + 1;
    rst_d <= RESET;
  end

  // TXLATCH monitor: pops the scoreboard and checks data and spacing.
  always @(negedge PHI2) begin
    if (bus.TXLATCH === 1'b1) begin
      launches++;
      total++;
      if (RESET || rst_d) begin
        bad++;
        $display("FAIL latch_near_reset: TXLATCH=1 data=%h, want no latch", bus.TXDATA);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_launch: data=%h, want no launch", bus.TXDATA);
      end else begin
        mon_exp = sb.pop_front();
        if (bus.TXDATA !== mon_exp) begin
          bad++;
          $display("FAIL txdata: got=%h want=%h", bus.TXDATA, mon_exp);
        end
      end
      total++;
      if (cyc - prev_launch < 3) begin
        bad++;
        $display("FAIL latch_spacing: got=%0d want>=3", cyc - prev_launch);
      end
      prev_launch = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge PHI2);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
  endtask

  task automatic cpu_send(input logic [7:0] d);
    bit got = 0;
    sb.push_back(d);
    bus.CPU_REQ  = 1'b1;
    bus.CPU_DATA = d;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge PHI2);
      if (bus.CPU_ACK === 1'b1) got = 1;
      tick();
    end
    bus.CPU_REQ = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL cpu_ack data=%h: got=0 want=1", d);
    end
  endtask

  task automatic wait_drain(input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && bus.IDLE === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_%s: pending=%0d idle=%b want pending=0 idle=1", tag, sb.size(), bus.IDLE);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    total++;
    if ({bus.CPU_ACK, bus.TXLATCH, bus.TXDATA, bus.FIFO_COUNT, bus.FIFO_EMPTY,
         bus.FIFO_FULL, bus.OVERRUN, bus.STALL, bus.IDLE} !== {2'b00, 8'h00, 3'd0, 5'b10001}) begin
      bad++;
      $display("FAIL reset_state: latch=%b data=%h cnt=%0d empty=%b full=%b ovr=%b stall=%b idle=%b want 0 00 0 1 0 0 0 1",
               bus.TXLATCH, bus.TXDATA, bus.FIFO_COUNT, bus.FIFO_EMPTY, bus.FIFO_FULL,
               bus.OVERRUN, bus.STALL, bus.IDLE);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lc;
    cpu_send(8'h41);
    total++;
    if (bus.TXLATCH !== 1'b1 || bus.TXDATA !== 8'h41) begin
      bad++;
      $display("FAIL first_launch: latch=%b data=%h want latch=1 data=41", bus.TXLATCH, bus.TXDATA);
    end
    tick();
    bus.TXFULL = 1'b1;
    cpu_send(8'h42);
    lc = launches;
    repeat (8) tick();
    total++;
    if (launches != lc || bus.FIFO_COUNT !== 3'd1) begin
      bad++;
      $display("FAIL txfull_block: launches=%0d cnt=%0d want launches=%0d cnt=1", launches, bus.FIFO_COUNT, lc);
    end
    bus.TXFULL = 1'b0;
    tick();
    total++;
    if (bus.TXLATCH !== 1'b1 || bus.TXDATA !== 8'h42) begin
      bad++;
      $display("FAIL launch_after_txfull: latch=%b data=%h want latch=1 data=42", bus.TXLATCH, bus.TXDATA);
    end
    tick();
    wait_drain("basic");
  endtask

  task automatic test_fifo_full();
    bit saw = 0;
    bus.TXFULL = 1'b1;
    for (int i = 1; i <= 4; i++) cpu_send(8'(i));
    total++;
    if (bus.FIFO_FULL !== 1'b1 || bus.FIFO_COUNT !== 3'd4) begin
      bad++;
      $display("FAIL fifo_full: full=%b cnt=%0d want full=1 cnt=4", bus.FIFO_FULL, bus.FIFO_COUNT);
    end
    sb.push_back(8'h05);
    bus.CPU_REQ  = 1'b1;
    bus.CPU_DATA = 8'h05;
    for (int i = 0; i < 5; i++) begin
      @(negedge PHI2);
      if (bus.CPU_ACK === 1'b1) saw = 1;
      tick();
    end
    total++;
    if (saw) begin
      bad++;
      $display("FAIL ack_when_full: got=1 want=0");
    end
    bus.TXFULL = 1'b0;
    @(negedge PHI2);
    total++;
    if (bus.CPU_ACK !== 1'b1 || bus.TXLATCH !== 1'b1) begin
      bad++;
      $display("FAIL push_pop_at_full: ack=%b latch=%b want ack=1 latch=1", bus.CPU_ACK, bus.TXLATCH);
    end
    tick();
    bus.CPU_REQ = 1'b0;
    total++;
    if (bus.FIFO_COUNT !== 3'd4) begin
      bad++;
      $display("FAIL count_push_pop: got=%0d want=4", bus.FIFO_COUNT);
    end
    wait_drain("fifo_full");
  endtask

  task automatic rr_round(input bit cpu_wins, input logic [7:0] c, input logic [7:0] e);
    bus.ECHO_WR   = 1'b1;
    bus.ECHO_DATA = e;
    tick();
    bus.ECHO_WR  = 1'b0;
    bus.CPU_REQ  = 1'b1;
    bus.CPU_DATA = c;
    if (cpu_wins) begin
      sb.push_back(c);
      sb.push_back(e);
    end else begin
      sb.push_back(e);
      sb.push_back(c);
    end
    @(negedge PHI2);
    total++;
    if (bus.CPU_ACK !== cpu_wins) begin
      bad++;
      $display("FAIL rr_grant c=%h: cpu_ack=%b want=%b", c, bus.CPU_ACK, cpu_wins);
    end
    tick();
    if (!cpu_wins) begin
      @(negedge PHI2);
      total++;
      if (bus.CPU_ACK !== 1'b1) begin
        bad++;
        $display("FAIL rr_loser c=%h: cpu_ack=%b want=1", c, bus.CPU_ACK);
      end
      tick();
    end
    bus.CPU_REQ = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.TXFULL = 1'b1;
    rr_round(1'b1, 8'hC1, 8'hE1);
    rr_round(1'b0, 8'hC2, 8'hE2);
    total++;
    if (bus.FIFO_COUNT !== 3'd4) begin
      bad++;
      $display("FAIL rr_count: got=%0d want=4", bus.FIFO_COUNT);
    end
    bus.TXFULL = 1'b0;
    wait_drain("rr_a");
    bus.TXFULL = 1'b1;
    rr_round(1'b1, 8'hC3, 8'hE3);
    rr_round(1'b0, 8'hC4, 8'hE4);
    bus.TXFULL = 1'b0;
    wait_drain("rr_b");
  endtask

  task automatic test_overrun();
    bus.TXFULL = 1'b1;
    for (int i = 0; i < 4; i++) cpu_send(8'hA0 + 8'(i));
    sb.push_back(8'h55);
    bus.ECHO_WR   = 1'b1;
    bus.ECHO_DATA = 8'h55;
    tick();
    bus.ECHO_DATA = 8'h66;
    tick();
    bus.ECHO_WR = 1'b0;
    total++;
    if (bus.OVERRUN !== 1'b1 || bus.IDLE !== 1'b0) begin
      bad++;
      $display("FAIL overrun_set: ovr=%b idle=%b want ovr=1 idle=0", bus.OVERRUN, bus.IDLE);
    end
    bus.ERR_CLR   = 1'b1;
    bus.ECHO_WR   = 1'b1;
    bus.ECHO_DATA = 8'h77;
    tick();
    bus.ERR_CLR = 1'b0;
    bus.ECHO_WR = 1'b0;
    total++;
    if (bus.OVERRUN !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear_priority: got=%b want=0", bus.OVERRUN);
    end
    bus.TXFULL = 1'b0;
    wait_drain("overrun");
  endtask

  task automatic test_echo_handoff();
    bus.TXFULL    = 1'b1;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    bus.ECHO_WR   = 1'b1;
    bus.ECHO_DATA = 8'h11;
    tick();
    bus.ECHO_DATA = 8'h22;
    tick();
    bus.ECHO_WR = 1'b0;
    tick();
    total++;
    if (bus.OVERRUN !== 1'b0 || bus.FIFO_COUNT !== 3'd2) begin
      bad++;
      $display("FAIL echo_handoff: ovr=%b cnt=%0d want ovr=0 cnt=2", bus.OVERRUN, bus.FIFO_COUNT);
    end
    bus.TXFULL = 1'b0;
    wait_drain("echo");
    bus.ECHO_EN   = 1'b0;
    bus.ECHO_WR   = 1'b1;
    bus.ECHO_DATA = 8'h99;
    tick();
    bus.ECHO_WR = 1'b0;
    bus.ECHO_EN = 1'b1;
    repeat (2) tick();
    total++;
    if (bus.IDLE !== 1'b1 || bus.FIFO_COUNT !== 3'd0) begin
      bad++;
      $display("FAIL echo_disabled: idle=%b cnt=%0d want idle=1 cnt=0", bus.IDLE, bus.FIFO_COUNT);
    end
  endtask

  task automatic test_hold_reset();
    int  lc;
    bit  found = 0;
    bus.HOLD = 1'b1;
    cpu_send(8'hB1);
    cpu_send(8'hB2);
    cpu_send(8'hB3);
    lc = launches;
    repeat (20) tick();
    total++;
    if (launches != lc) begin
      bad++;
      $display("FAIL hold_block: launches=%0d want=%0d", launches, lc);
    end
    bus.HOLD = 1'b0;
    #1;
    total++;
    if (bus.TXLATCH !== 1'b1 || bus.TXDATA !== 8'hB1) begin
      bad++;
      $display("FAIL hold_release: latch=%b data=%h want latch=1 data=b1", bus.TXLATCH, bus.TXDATA);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.TXLATCH === 1'b1) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL second_launch: got none want latch within 10 cycles");
    end
    tick();
    RESET = 1'b1;
    sb.delete();
    repeat (2) tick();
    RESET = 1'b0;
    tick();
    total++;
    if (bus.FIFO_COUNT !== 3'd0 || bus.IDLE !== 1'b1) begin
      bad++;
      $display("FAIL mid_drain_reset: cnt=%0d idle=%b want cnt=0 idle=1", bus.FIFO_COUNT, bus.IDLE);
    end
    lc = launches;
    repeat (20) tick();
    total++;
    if (launches != lc) begin
      bad++;
      $display("FAIL launch_after_reset: launches=%0d want=%0d", launches, lc);
    end
  endtask

  task automatic test_wdog();
    cpu_send(8'h5A);
    tick();
    bus.TXFULL = 1'b1;
`ifdef ACIA_TX_SCHED_WDOG_EN
    repeat (16) tick();
    total++;
    if (bus.STALL !== 1'b0) begin
      bad++;
      $display("FAIL stall_early: got=%b want=0", bus.STALL);
    end
    tick();
    total++;
    if (bus.STALL !== 1'b1 || bus.IDLE !== 1'b1) begin
      bad++;
      $display("FAIL stall_timeout: stall=%b idle=%b want stall=1 idle=1", bus.STALL, bus.IDLE);
    end
    bus.ERR_CLR = 1'b1;
    tick();
    bus.ERR_CLR = 1'b0;
    total++;
    if (bus.STALL !== 1'b0) begin
      bad++;
      $display("FAIL stall_clear: got=%b want=0", bus.STALL);
    end
`else
    repeat (40) tick();
    total++;
    if (bus.STALL !== 1'b0 || bus.IDLE !== 1'b0) begin
      bad++;
      $display("FAIL no_wdog: stall=%b idle=%b want stall=0 idle=0", bus.STALL, bus.IDLE);
    end
`endif
    bus.TXFULL = 1'b0;
    wait_drain("wdog");
  endtask

  initial begin
    bus.CPU_REQ   = 1'b0;
    bus.CPU_DATA  = '0;
    bus.ECHO_WR   = 1'b0;
    bus.ECHO_DATA = '0;
    bus.ECHO_EN   = 1'b1;
    bus.HOLD      = 1'b0;
    bus.TXFULL    = 1'b0;
    bus.ERR_CLR   = 1'b0;
    test_reset();
    test_basic();
    test_fifo_full();
    test_round_robin();
    test_overrun();
    test_echo_handoff();
    test_hold_reset();
    test_wdog();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
